// File: rtl/uart_pkg.sv
// Shared UART definitions: common data width and the transmit-queue FSM encoding.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic {
      Q_IDLE,
      Q_WAIT_DONE
   } txq_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Single-clock circular-buffer FIFO with explicit occupancy count, flush and a sticky overflow flag.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   input  logic                     flush,
   input  logic                     clr_ovf,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_wr;
   logic              do_rd;
   logic              ovf_set;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign ovf_set = wr_en && full;
   assign rd_data = mem[rd_ptr];

   // NOTE: storage has no reset; the pointers and level define which entries are valid,
   // so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // A dropped write outranks a clear request so the event is never lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_queue.sv
// Transmit byte queue: buffers host writes and launches them one at a time into the UART transmitter.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     flush,
   input  logic                     clr_ovf,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     newd,
   output logic [DATA_W-1:0]        dintx,
   input  logic                     tx_busy,
   input  logic                     donetx
);

   txq_state_t        state;
   txq_state_t        state_nxt;
   logic              launch;
   logic              newd_nxt;
   logic [DATA_W-1:0] dintx_nxt;
   logic [DATA_W-1:0] head_data;

   uart_sync_fifo #(
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (launch),
      .flush    (flush),
      .clr_ovf  (clr_ovf),
      .rd_data  (head_data),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow)
   );

   // tx_busy only matters while idle; once launched we wait for donetx alone.
   assign launch = (state == Q_IDLE) && !empty && !tx_busy && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= Q_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         Q_IDLE: begin
            if (launch) begin
               state_nxt = Q_WAIT_DONE;
            end
         end
         Q_WAIT_DONE: begin
            if (donetx) begin
               state_nxt = Q_IDLE;
            end
         end
         default: state_nxt = Q_IDLE;
      endcase
   end

   always_comb begin
      newd_nxt  = launch;
      dintx_nxt = dintx;
      if (launch) begin
         dintx_nxt = head_data;
      end
   end

   // dintx only moves on a launch edge, so it stays stable for the whole frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         newd  <= 1'b0;
         dintx <= '0;
      end else begin
         newd  <= newd_nxt;
         dintx <= dintx_nxt;
      end
   end

endmodule : uart_tx_queue

// File: tb/tb_uart_tx_queue.sv
// Randomized self-checking bench for uart_tx_queue against a queue-based reference model.
module tb_uart_tx_queue;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       flush;
   logic       clr_ovf;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic       overflow;
   logic       newd;
   logic [7:0] dintx;
   logic       tx_busy;
   logic       donetx;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] m_q[$];
   bit         m_wait;
   bit         m_ovf;
   bit         m_newd;
   logic [7:0] m_dintx;
   int         tx_cnt;
   bit         hold_busy;
   bit         rand_busy;
   bit         prev_newd;
   int         act_emitted;

   uart_tx_queue #(.DEPTH(DEPTH), .DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .flush    (flush),
      .clr_ovf  (clr_ovf),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .newd     (newd),
      .dintx    (dintx),
      .tx_busy  (tx_busy),
      .donetx   (donetx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_wait  = 1'b0;
      m_ovf   = 1'b0;
      m_newd  = 1'b0;
      m_dintx = 8'h00;
      tx_cnt  = -1;
      prev_newd = 1'b0;
   endtask

   task automatic check_all();
      check("level",    32'(level),    32'(m_q.size()));
      check("empty",    32'(empty),    32'(m_q.size() == 0));
      check("full",     32'(full),     32'(m_q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("newd",     32'(newd),     32'(m_newd));
      check("dintx",    32'(dintx),    32'(m_dintx));
      check("newd_b2b", 32'(newd && prev_newd), 32'(0));
   endtask

   // One clock: update the model from the inputs held across the edge, compare, then drive the transmitter model.
   task automatic step();
      bit launch;
      bit wr_ok;
      @(posedge clk);
      launch = !m_wait && (m_q.size() > 0) && !tx_busy && !flush;
      wr_ok  = wr_en && (m_q.size() < DEPTH);
      if (wr_en && m_q.size() == DEPTH) m_ovf = 1'b1;
      else if (clr_ovf)                 m_ovf = 1'b0;
      if (flush) begin
         m_q.delete();
      end else begin
         if (launch) m_dintx = m_q.pop_front();
         if (wr_ok)  m_q.push_back(wr_data);
      end
      if (launch)                m_wait = 1'b1;
      else if (m_wait && donetx) m_wait = 1'b0;
      m_newd = launch;
      #1;
      check_all();
      if (newd === 1'b1) act_emitted++;
      prev_newd = newd;
      if (m_newd) tx_cnt = int'($urandom_range(0, 4));
      if (tx_cnt > 0) begin
         tx_busy = 1'b1;
         donetx  = 1'b0;
         tx_cnt--;
      end else if (tx_cnt == 0) begin
         tx_busy = 1'b0;
         donetx  = 1'b1;
         tx_cnt  = -1;
      end else begin
         tx_busy = hold_busy || (rand_busy && $urandom_range(0, 3) == 0);
         donetx  = !m_wait && rand_busy && ($urandom_range(0, 7) == 0);
      end
   endtask

   task automatic cyc(input bit w, input logic [7:0] d, input bit fl, input bit co);
      wr_en   = w;
      wr_data = d;
      flush   = fl;
      clr_ovf = co;
      step();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((m_q.size() > 0 || m_wait || tx_cnt != -1) && n < budget) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b0);
         n++;
      end
      check("drain_timeout", 32'(n < budget), 32'(1));
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      int base;
      int n;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_ovf = 1'b0;
      tx_busy = 1'b0; donetx = 1'b0;
      hold_busy = 1'b0; rand_busy = 1'b0; act_emitted = 0;
      model_reset();

      // Reset values while held in reset
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rst = 1'b1;

      // Async reset clears a queued byte without a clock edge
      hold_busy = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("async_rst_level", 32'(level), 32'(0));
      check("async_rst_empty", 32'(empty), 32'(1));
      check("async_rst_newd",  32'(newd),  32'(0));
      model_reset();
      hold_busy = 1'b0; tx_busy = 1'b0; donetx = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Single byte
      cyc(1'b1, 8'h3C, 1'b0, 1'b0);
      drain(40);
      check("single_count", 32'(act_emitted), 32'(1));

      // Burst 0x01..0x05
      base = act_emitted;
      for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      drain(100);
      check("burst_count", 32'(act_emitted - base), 32'(5));

      // Full and overflow with the transmitter held busy
      hold_busy = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      base = act_emitted;
      for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check("full_no_launch", 32'(act_emitted - base), 32'(0));
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      hold_busy = 1'b0;
      drain(300);
      check("full_emit_count", 32'(act_emitted - base), 32'(16));

      // Wrap with writes coinciding with pops
      n = 0;
      while (n < 40) begin
         if ($urandom_range(0, 1) == 1) begin
            cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
            n++;
         end else begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
         end
      end
      drain(400);

      // Flush mid-frame
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      n = 0;
      while (!(m_wait && m_q.size() > 0) && n < 50) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b0);
         n++;
      end
      check("flush_wait_timeout", 32'(n < 50), 32'(1));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      base = act_emitted;
      repeat (40) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check("flush_no_launch", 32'(act_emitted - base), 32'(0));

      // Random traffic
      rand_busy = 1'b1;
      repeat (800) begin
         cyc($urandom_range(0, 9) < 6, 8'($urandom),
             $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0);
      end
      rand_busy = 1'b0;
      drain(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_tx_queue
